// File: rtl/signed_product_accumulator.sv
// Sums COUNT signed products per block into a saturating accumulator and
// presents the finished sum on a valid/ready port, stalling the input meanwhile.
module signed_product_accumulator #(
    parameter int PROD_W = 9,
    parameter int ACC_W  = 16,
    parameter int COUNT  = 4
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     Clear,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [PROD_W-1:0] Product,
    output logic                     acc_valid,
    input  logic                     acc_ready,
    output logic signed [ACC_W-1:0]  Accum,
    output logic                     Overflow,
    output logic [3:0]               Count
);

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    localparam logic [3:0] COUNT_LAST = 4'(COUNT);

    state_t                   r_state;
    logic signed [ACC_W-1:0]  r_accum;
    logic                     r_overflow;
    logic [3:0]               r_count;

    logic signed [ACC_W:0]    w_sum;
    logic signed [ACC_W-1:0]  w_sat;
    logic                     w_sat_hit;
    logic [3:0]               w_count_next;

    // One guard bit is enough: the sum of two values that fit ACC_W bits fits ACC_W+1.
    assign w_sum        = {r_accum[ACC_W-1], r_accum}
                        + {{(ACC_W+1-PROD_W){Product[PROD_W-1]}}, Product};
    assign w_count_next = r_count + 4'd1;

    // Clamp the widened sum to the ACC_W-bit signed range.
    always_comb begin
        w_sat_hit = 1'b0;
        w_sat     = w_sum[ACC_W-1:0];
        if (w_sum[ACC_W] != w_sum[ACC_W-1]) begin
            w_sat_hit = 1'b1;
            if (w_sum[ACC_W] == 1'b0) begin
                w_sat = {1'b0, {(ACC_W-1){1'b1}}};
            end else begin
                w_sat = {1'b1, {(ACC_W-1){1'b0}}};
            end
        end else begin
            w_sat = w_sum[ACC_W-1:0];
        end
    end

    // Block state: accumulate, hold for the handshake, abort on Clear.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state    <= ST_ACCUM;
            r_accum    <= '0;
            r_overflow <= 1'b0;
            r_count    <= 4'd0;
        end else if (Clear) begin
            r_state    <= ST_ACCUM;
            r_accum    <= '0;
            r_overflow <= 1'b0;
            r_count    <= 4'd0;
        end else begin
            case (r_state)
                ST_HOLD: begin
                    if (acc_ready) begin
                        r_state    <= ST_ACCUM;
                        r_accum    <= '0;
                        r_overflow <= 1'b0;
                        r_count    <= 4'd0;
                    end
                end
                ST_ACCUM: begin
                    if (in_valid) begin
                        r_accum    <= w_sat;
                        r_overflow <= r_overflow | w_sat_hit;
                        r_count    <= w_count_next;
                        if (w_count_next == COUNT_LAST) begin
                            r_state <= ST_HOLD;
                        end
                    end
                end
                default: begin
                    r_state    <= ST_ACCUM;
                    r_accum    <= '0;
                    r_overflow <= 1'b0;
                    r_count    <= 4'd0;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == ST_ACCUM) & ~Clear;
    assign acc_valid = (r_state == ST_HOLD);
    assign Accum     = r_accum;
    assign Overflow  = r_overflow;
    assign Count     = r_count;

endmodule

// File: tb/tb_signed_product_accumulator.sv
// Drives a 16-bit and a 10-bit accumulator with shared stimulus and checks both
// against an integer-arithmetic reference model.
module tb_signed_product_accumulator;

    localparam int COUNT = 4;

    logic               clk;
    logic               rst;
    logic               clr;
    logic               in_valid;
    logic signed [8:0]  prod;
    logic               acc_ready;

    logic               in_ready0, acc_valid0, ovf0;
    logic signed [15:0] acc0;
    logic [3:0]         cnt0;
    logic               in_ready1, acc_valid1, ovf1;
    logic signed [9:0]  acc1;
    logic [3:0]         cnt1;

    int errors = 0;
    int checks = 0;

    longint m_acc [2];
    bit     m_ovf [2];
    int     m_cnt [2];
    bit     m_hold[2];
    int     m_w   [2] = '{16, 10};

    signed_product_accumulator #(.PROD_W(9), .ACC_W(16), .COUNT(COUNT)) u_dut16 (
        .Clock(clk), .Reset(rst), .Clear(clr), .in_valid(in_valid), .in_ready(in_ready0),
        .Product(prod), .acc_valid(acc_valid0), .acc_ready(acc_ready),
        .Accum(acc0), .Overflow(ovf0), .Count(cnt0)
    );

    signed_product_accumulator #(.PROD_W(9), .ACC_W(10), .COUNT(COUNT)) u_dut10 (
        .Clock(clk), .Reset(rst), .Clear(clr), .in_valid(in_valid), .in_ready(in_ready1),
        .Product(prod), .acc_valid(acc_valid1), .acc_ready(acc_ready),
        .Accum(acc1), .Overflow(ovf1), .Count(cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_acc[i] = 0; m_ovf[i] = 0; m_cnt[i] = 0; m_hold[i] = 0;
        end
    endtask

    task automatic model_edge();
        longint s, hi, lo;
        for (int i = 0; i < 2; i++) begin
            hi = (longint'(1) <<< (m_w[i] - 1)) - 1;
            lo = -hi - 1;
            if (clr) begin
                m_acc[i] = 0; m_ovf[i] = 0; m_cnt[i] = 0; m_hold[i] = 0;
            end else if (m_hold[i]) begin
                if (acc_ready) begin
                    m_acc[i] = 0; m_ovf[i] = 0; m_cnt[i] = 0; m_hold[i] = 0;
                end
            end else if (in_valid) begin
                s = m_acc[i] + longint'(prod);
                if (s > hi) begin s = hi; m_ovf[i] = 1; end
                else if (s < lo) begin s = lo; m_ovf[i] = 1; end
                m_acc[i] = s;
                m_cnt[i]++;
                if (m_cnt[i] == COUNT) m_hold[i] = 1;
            end
        end
    endtask

    task automatic check_all();
        chk("acc16",   longint'(acc0), m_acc[0]);
        chk("cnt16",   longint'(cnt0), m_cnt[0]);
        chk("ovf16",   longint'(ovf0), longint'(m_ovf[0]));
        chk("valid16", longint'(acc_valid0), longint'(m_hold[0]));
        chk("rdy16",   longint'(in_ready0), longint'(!m_hold[0] && !clr));
        chk("acc10",   longint'(acc1), m_acc[1]);
        chk("cnt10",   longint'(cnt1), m_cnt[1]);
        chk("ovf10",   longint'(ovf1), longint'(m_ovf[1]));
        chk("valid10", longint'(acc_valid1), longint'(m_hold[1]));
        chk("rdy10",   longint'(in_ready1), longint'(!m_hold[1] && !clr));
    endtask

    // Apply inputs, take one rising edge, then compare after it has settled.
    task automatic step(input logic v, input int p, input logic r, input logic c);
        in_valid  = v;
        prod      = 9'(p);
        acc_ready = r;
        clr       = c;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; prod = '0; acc_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;

        // Four accepts of 21 with the consumer always ready.
        for (int k = 1; k <= 4; k++) begin
            step(1'b1, 21, 1'b1, 1'b0);
            chk("t1_cnt", longint'(cnt0), k);
            chk("t1_acc", longint'(acc0), 21 * k);
        end
        chk("t1_valid", longint'(acc_valid0), 1);
        chk("t1_ovf", longint'(ovf0), 0);
        step(1'b1, 21, 1'b1, 1'b0);
        chk("t1_acc_after", longint'(acc0), 0);
        chk("t1_rdy_after", longint'(in_ready0), 1);
        chk("t1_valid_after", longint'(acc_valid0), 0);

        // Back-pressure: sum of -1 held while the consumer stalls.
        step(1'b1, -21, 1'b0, 1'b0);
        step(1'b1, 21, 1'b0, 1'b0);
        step(1'b1, -256, 1'b0, 1'b0);
        step(1'b1, 255, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step(1'b1, int'($urandom_range(0, 511)), 1'b0, 1'b0);
            chk("t2_hold_acc", longint'(acc0), -1);
            chk("t2_hold_valid", longint'(acc_valid0), 1);
        end
        step(1'b0, 0, 1'b1, 1'b0);
        chk("t2_release", longint'(acc_valid0), 0);

        // Positive saturation on the narrow accumulator.
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 255, 1'b0, 1'b0);
            chk("t3_acc10", longint'(acc1), (k == 0) ? 255 : (k == 1) ? 510 : 511);
            chk("t3_ovf10", longint'(ovf1), (k >= 2) ? 1 : 0);
        end
        step(1'b0, 0, 1'b1, 1'b0);
        step(1'b1, 1, 1'b0, 1'b0);
        chk("t3_ovf_new", longint'(ovf1), 0);
        step(1'b0, 0, 1'b0, 1'b1);

        // Negative saturation on the narrow accumulator.
        for (int k = 0; k < 4; k++) begin
            step(1'b1, -256, 1'b0, 1'b0);
            chk("t4_acc10", longint'(acc1), (k == 0) ? -256 : -512);
        end
        chk("t4_ovf10", longint'(ovf1), 1);
        step(1'b0, 0, 1'b1, 1'b0);

        // Clear mid-block with a valid input in the same cycle.
        step(1'b1, 21, 1'b0, 1'b0);
        step(1'b1, 21, 1'b0, 1'b0);
        step(1'b1, 21, 1'b0, 1'b1);
        chk("t5_acc", longint'(acc0), 0);
        chk("t5_cnt", longint'(cnt0), 0);
        for (int k = 0; k < 4; k++) step(1'b1, 1, 1'b0, 1'b0);
        chk("t5_sum", longint'(acc0), 4);
        step(1'b0, 0, 1'b1, 1'b1);

        // Asynchronous reset between edges after three accepts.
        for (int k = 0; k < 3; k++) step(1'b1, 21, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        model_reset();
        #1;
        check_all();
        chk("t6_async_cnt", longint'(cnt0), 0);
        @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) step(1'b1, -21, 1'b0, 1'b0);
        chk("t6_sum", longint'(acc0), -84);
        step(1'b0, 0, 1'b1, 1'b0);

        // Randomized traffic, including extremes and occasional Clear.
        for (int n = 0; n < 400; n++) begin
            int p;
            p = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? 255 : -256)
                                            : int'($urandom_range(0, 511)) - 256;
            step(1'($urandom_range(0, 3) != 0), p, 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 24) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
